// File: rtl/clause_pkg.sv
// -----------------------------------------------------------------------------
// clause_pkg
// Shared types and default sizing for the clause evaluation pipeline.
//   lane_class_e  : per-lane classification result
//   implication_t : one implied assignment (variable, value, source clause)
//   DEF_*         : default parameter values used by the modules
// -----------------------------------------------------------------------------
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package clause_pkg;

    localparam int DEF_LITS     = 5;
    localparam int DEF_LANES    = 2;
    localparam int DEF_VAR_BITS = `MAX_VARS_BITS;
    localparam int DEF_CID_BITS = 16;
    localparam int DEF_DEPTH    = 4;

    typedef enum logic [2:0] {
        CL_EMPTY,
        CL_SAT,
        CL_UNIT,
        CL_CONFLICT,
        CL_OPEN
    } lane_class_e;

    // 'var' is a keyword, so the variable field is called var_idx.
    typedef struct packed {
        logic [DEF_VAR_BITS-1:0] var_idx;
        logic                    val;
        logic [DEF_CID_BITS-1:0] clause_id;
    } implication_t;

endpackage

// File: rtl/clause_eval_pipe_classifier.sv
// -----------------------------------------------------------------------------
// clause_classifier
// Purely combinational classification of one clause (one lane).
//   mask/unassign/pole/val : per-literal state bits
//   lit_var                : variable index per literal
//   lane_class             : EMPTY / SAT / UNIT / CONFLICT / OPEN
//   imp_var / imp_val      : implied assignment, meaningful only for UNIT
// -----------------------------------------------------------------------------
module clause_classifier
    import clause_pkg::*;
#(
    parameter int LITS     = DEF_LITS,
    parameter int VAR_BITS = DEF_VAR_BITS
) (
    input  logic [LITS-1:0]               mask,
    input  logic [LITS-1:0]               unassign,
    input  logic [LITS-1:0]               pole,
    input  logic [LITS-1:0]               val,
    input  logic [LITS-1:0][VAR_BITS-1:0] lit_var,
    output lane_class_e                   lane_class,
    output logic [VAR_BITS-1:0]           imp_var,
    output logic                          imp_val
);

    logic [LITS-1:0] true_v;
    logic [LITS-1:0] free_v;
    logic            free_one_hot;

    assign true_v = mask & ~unassign & (val ^ pole);
    assign free_v = mask & unassign;

    // Exact one-hot test: non-zero and clearing the lowest set bit leaves zero.
    assign free_one_hot = (free_v != '0) && ((free_v & (free_v - LITS'(1))) == '0);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block can infer a latch.
        lane_class = CL_OPEN;
        if (mask == '0) begin
            lane_class = CL_EMPTY;
        end else if (true_v != '0) begin
            lane_class = CL_SAT;
        end else if (free_one_hot) begin
            lane_class = CL_UNIT;
        end else if (free_v == '0) begin
            lane_class = CL_CONFLICT;
        end
    end

    // With a one-hot free vector an OR of the selected entries is the mux.
    always_comb begin
        imp_var = '0;
        for (int i = 0; i < LITS; i++) begin
            if (free_v[i]) begin
                imp_var = imp_var | lit_var[i];
            end
        end
    end

    assign imp_val = ~|(free_v & pole);

endmodule

// File: rtl/clause_eval_pipe.sv
// -----------------------------------------------------------------------------
// clause_eval_pipe
// One-stage, multi-lane clause evaluator. A beat of LANES clauses is held in a
// stage register, classified per lane, and its UNIT implications are pushed
// one per cycle into a DEPTH-entry FIFO. A CONFLICT lane discards the beat,
// raises a sticky flag and blocks intake until conflict_clear.
//   in_valid/in_ready      : beat handshake
//   in_clause_id           : ID of lane 0 (lane k = id + k, wrapping)
//   in_unassign/mask/pole/val/var : per-lane, per-literal clause state
//   out_valid/out_ready    : implication handshake, out_* is the FIFO head
//   conflict/conflict_clause_id : sticky flag and lowest conflicting lane ID
//   conflict_clear         : clears the flag and flushes the FIFO
//   busy                   : stage occupied or FIFO non-empty
// -----------------------------------------------------------------------------
module clause_eval_pipe
    import clause_pkg::*;
#(
    parameter int LITS     = DEF_LITS,
    parameter int LANES    = DEF_LANES,
    parameter int VAR_BITS = DEF_VAR_BITS,
    parameter int CID_BITS = DEF_CID_BITS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [CID_BITS-1:0]                    in_clause_id,
    input  logic [LANES-1:0][LITS-1:0]             in_unassign,
    input  logic [LANES-1:0][LITS-1:0]             in_mask,
    input  logic [LANES-1:0][LITS-1:0]             in_pole,
    input  logic [LANES-1:0][LITS-1:0]             in_val,
    input  logic [LANES-1:0][LITS-1:0][VAR_BITS-1:0] in_var,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [VAR_BITS-1:0]                    out_var,
    output logic                                   out_val,
    output logic [CID_BITS-1:0]                    out_clause_id,
    output logic                                   conflict,
    output logic [CID_BITS-1:0]                    conflict_clause_id,
    input  logic                                   conflict_clear,
    output logic                                   busy
);

    localparam int PTR_BITS  = $clog2(DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;

    // Width-parametric counterpart of clause_pkg::implication_t.
    typedef struct packed {
        logic [VAR_BITS-1:0] var_idx;
        logic                val;
        logic [CID_BITS-1:0] clause_id;
    } imp_t;

    // ---------------- state ----------------
    logic                              stage_valid_q,   stage_valid_d;
    logic [CID_BITS-1:0]               stage_id_q,      stage_id_d;
    logic [LANES-1:0][LITS-1:0]        stage_unassign_q, stage_unassign_d;
    logic [LANES-1:0][LITS-1:0]        stage_mask_q,    stage_mask_d;
    logic [LANES-1:0][LITS-1:0]        stage_pole_q,    stage_pole_d;
    logic [LANES-1:0][LITS-1:0]        stage_val_q,     stage_val_d;
    logic [LANES-1:0][LITS-1:0][VAR_BITS-1:0] stage_var_q, stage_var_d;
    logic [LANES-1:0]                  pending_q,       pending_d;
    logic                              conflict_q,      conflict_d;
    logic [CID_BITS-1:0]               conflict_id_q,   conflict_id_d;
    logic [PTR_BITS-1:0]               wr_ptr_q,        wr_ptr_d;
    logic [PTR_BITS-1:0]               rd_ptr_q,        rd_ptr_d;
    logic [CNT_BITS-1:0]               count_q,         count_d;
    imp_t                              fifo_mem_q [DEPTH];

    // ---------------- per-lane classification ----------------
    lane_class_e                       lane_class [LANES];
    logic [LANES-1:0][VAR_BITS-1:0]    lane_var;
    logic [LANES-1:0]                  lane_val;
    logic [LANES-1:0]                  unit_vec;
    logic [LANES-1:0]                  conf_vec;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        clause_classifier #(
            .LITS     (LITS),
            .VAR_BITS (VAR_BITS)
        ) u_classifier (
            .mask       (stage_mask_q[k]),
            .unassign   (stage_unassign_q[k]),
            .pole       (stage_pole_q[k]),
            .val        (stage_val_q[k]),
            .lit_var    (stage_var_q[k]),
            .lane_class (lane_class[k]),
            .imp_var    (lane_var[k]),
            .imp_val    (lane_val[k])
        );
        assign unit_vec[k] = (lane_class[k] == CL_UNIT);
        assign conf_vec[k] = (lane_class[k] == CL_CONFLICT);
    end

    // ---------------- control ----------------
    logic [LANES-1:0]     pend;
    logic [LANES-1:0]     pend_left;
    logic [LANE_BITS-1:0] push_lane;
    logic [LANE_BITS-1:0] conf_lane;
    logic                 any_conflict;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 retire;
    logic                 accept;
    logic                 flush;
    imp_t                 push_imp;
    imp_t                 head;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count_q == CNT_BITS'(DEPTH));

    always_comb begin
        // pending_q is loaded all-ones on intake; masking with the live UNIT
        // vector turns it into "UNIT lanes not yet pushed".
        pend         = pending_q & unit_vec;
        any_conflict = stage_valid_q && (conf_vec != '0);

        // Descending scans so the lowest set lane wins.
        push_lane = '0;
        conf_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (pend[k])     push_lane = LANE_BITS'(k);
            if (conf_vec[k]) conf_lane = LANE_BITS'(k);
        end

        push      = stage_valid_q && !any_conflict && (pend != '0) && !fifo_full;
        pend_left = pend;
        if (push) begin
            pend_left[push_lane] = 1'b0;
        end
        retire   = stage_valid_q && !any_conflict && (pend_left == '0);
        in_ready = !conflict_q && (!stage_valid_q || retire);
        accept   = in_valid && in_ready;
        flush    = conflict_q && conflict_clear;

        push_imp.var_idx   = lane_var[push_lane];
        push_imp.val       = lane_val[push_lane];
        push_imp.clause_id = stage_id_q + CID_BITS'(push_lane);

        // Stage register.
        stage_valid_d    = stage_valid_q;
        stage_id_d       = stage_id_q;
        stage_unassign_d = stage_unassign_q;
        stage_mask_d     = stage_mask_q;
        stage_pole_d     = stage_pole_q;
        stage_val_d      = stage_val_q;
        stage_var_d      = stage_var_q;
        pending_d        = pending_q;
        if (accept) begin
            stage_valid_d    = 1'b1;
            stage_id_d       = in_clause_id;
            stage_unassign_d = in_unassign;
            stage_mask_d     = in_mask;
            stage_pole_d     = in_pole;
            stage_val_d      = in_val;
            stage_var_d      = in_var;
            pending_d        = '1;
        end else if (retire || any_conflict) begin
            stage_valid_d = 1'b0;
            pending_d     = '0;
        end else if (push) begin
            pending_d = pending_q & ~(LANES'(1) << push_lane);
        end

        // Sticky conflict. A conflict can only be detected while the flag is
        // low (the stage is empty whenever it is high), so the two never race.
        conflict_d    = conflict_q;
        conflict_id_d = conflict_id_q;
        if (any_conflict) begin
            conflict_d    = 1'b1;
            conflict_id_d = stage_id_q + CID_BITS'(conf_lane);
        end else if (flush) begin
            conflict_d = 1'b0;
        end

        // FIFO pointers; DEPTH is a power of two so pointers wrap naturally.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_BITS'(1);
                2'b01:   count_d = count_q - CNT_BITS'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q    <= 1'b0;
            stage_id_q       <= '0;
            stage_unassign_q <= '0;
            stage_mask_q     <= '0;
            stage_pole_q     <= '0;
            stage_val_q      <= '0;
            stage_var_q      <= '0;
            pending_q        <= '0;
            conflict_q       <= 1'b0;
            conflict_id_q    <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            stage_valid_q    <= stage_valid_d;
            stage_id_q       <= stage_id_d;
            stage_unassign_q <= stage_unassign_d;
            stage_mask_q     <= stage_mask_d;
            stage_pole_q     <= stage_pole_d;
            stage_val_q      <= stage_val_d;
            stage_var_q      <= stage_var_d;
            pending_q        <= pending_d;
            conflict_q       <= conflict_d;
            conflict_id_q    <= conflict_id_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
        end
    end

    // NOTE: the storage array is not reset; the count gates every read, so
    // stale entries are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_imp;
        end
    end

    // Head outputs are forced to zero when empty so reset values hold without
    // resetting the array.
    assign head               = fifo_mem_q[rd_ptr_q];
    assign out_var            = out_valid ? head.var_idx   : '0;
    assign out_val            = out_valid ? head.val       : 1'b0;
    assign out_clause_id      = out_valid ? head.clause_id : '0;
    assign conflict           = conflict_q;
    assign conflict_clause_id = conflict_id_q;
    assign busy               = stage_valid_q || out_valid;

endmodule

// File: tb/tb_clause_eval_pipe.sv
// -----------------------------------------------------------------------------
// tb_clause_eval_pipe
// Directed scenarios plus randomized traffic for clause_eval_pipe, checked
// against a counting-based clause model and an expected-implication queue.
// -----------------------------------------------------------------------------
module tb_clause_eval_pipe;

    localparam int LITS  = 5;
    localparam int LANES = 2;
    localparam int VB    = 8;
    localparam int CB    = 16;
    localparam int DEPTH = 4;

    localparam int K_EMPTY = 0;
    localparam int K_SAT   = 1;
    localparam int K_UNIT  = 2;
    localparam int K_CONF  = 3;
    localparam int K_OPEN  = 4;

    logic                                 clk;
    logic                                 rst_n;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [CB-1:0]                        in_clause_id;
    logic [LANES-1:0][LITS-1:0]           in_unassign;
    logic [LANES-1:0][LITS-1:0]           in_mask;
    logic [LANES-1:0][LITS-1:0]           in_pole;
    logic [LANES-1:0][LITS-1:0]           in_val;
    logic [LANES-1:0][LITS-1:0][VB-1:0]   in_var;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [VB-1:0]                        out_var;
    logic                                 out_val;
    logic [CB-1:0]                        out_clause_id;
    logic                                 conflict;
    logic [CB-1:0]                        conflict_clause_id;
    logic                                 conflict_clear;
    logic                                 busy;

    clause_eval_pipe #(
        .LITS(LITS), .LANES(LANES), .VAR_BITS(VB), .CID_BITS(CB), .DEPTH(DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_clause_id       (in_clause_id),
        .in_unassign        (in_unassign),
        .in_mask            (in_mask),
        .in_pole            (in_pole),
        .in_val             (in_val),
        .in_var             (in_var),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_var            (out_var),
        .out_val            (out_val),
        .out_clause_id      (out_clause_id),
        .conflict           (conflict),
        .conflict_clause_id (conflict_clause_id),
        .conflict_clear     (conflict_clear),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [VB-1:0] v;
        logic          b;
        logic [CB-1:0] id;
    } imp_s;

    imp_s          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            exp_conf;
    logic [CB-1:0] exp_conf_id;

    // ---------------- reference model ----------------
    function automatic int lane_kind(input logic [LITS-1:0] m, u, p, v);
        int n_act  = 0;
        int n_free = 0;
        bit sat    = 0;
        for (int i = 0; i < LITS; i++) begin
            if (m[i]) begin
                n_act++;
                if (u[i])            n_free++;
                else if (v[i] != p[i]) sat = 1;
            end
        end
        if (n_act == 0)  return K_EMPTY;
        if (sat)         return K_SAT;
        if (n_free == 1) return K_UNIT;
        if (n_free == 0) return K_CONF;
        return K_OPEN;
    endfunction

    // Called just before a transferring edge: records what this beat must do.
    task automatic model_beat();
        imp_s e;
        int   f;
        int   kind;
        exp_conf    = 0;
        exp_conf_id = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_kind(in_mask[k], in_unassign[k], in_pole[k], in_val[k]) == K_CONF) begin
                exp_conf    = 1;
                exp_conf_id = in_clause_id + CB'(k);
            end
        end
        if (!exp_conf) begin
            for (int k = 0; k < LANES; k++) begin
                kind = lane_kind(in_mask[k], in_unassign[k], in_pole[k], in_val[k]);
                if (kind == K_UNIT) begin
                    f = 0;
                    for (int i = 0; i < LITS; i++)
                        if (in_mask[k][i] && in_unassign[k][i]) f = i;
                    e.v  = in_var[k][f];
                    e.b  = ~in_pole[k][f];
                    e.id = in_clause_id + CB'(k);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_lane(input int k, input logic [LITS-1:0] m, u, p, v);
        in_mask[k]     = m;
        in_unassign[k] = u;
        in_pole[k]     = p;
        in_val[k]      = v;
        for (int i = 0; i < LITS; i++) in_var[k][i] = VB'($urandom);
    endtask

    task automatic unit_lane(input int k);
        int              f;
        logic [LITS-1:0] m;
        logic [LITS-1:0] p;
        f = $urandom_range(0, LITS - 1);
        m = LITS'($urandom) | (LITS'(1) << f);
        p = LITS'($urandom);
        set_lane(k, m, LITS'(1) << f, p, p);
    endtask

    task automatic sat_lane(input int k);
        int              t;
        logic [LITS-1:0] m;
        logic [LITS-1:0] u;
        logic [LITS-1:0] p;
        t = $urandom_range(0, LITS - 1);
        m = LITS'($urandom) | (LITS'(1) << t);
        u = LITS'($urandom) & ~(LITS'(1) << t);
        p = LITS'($urandom);
        set_lane(k, m, u, p, p ^ (LITS'(1) << t));
    endtask

    task automatic rand_lane(input int k);
        int r;
        r = $urandom_range(0, 4);
        case (r)
            0, 1: unit_lane(k);
            2:    sat_lane(k);
            3:    set_lane(k, '0, LITS'($urandom), LITS'($urandom), LITS'($urandom));
            default: begin
                do begin
                    set_lane(k, LITS'($urandom), LITS'($urandom), LITS'($urandom), LITS'($urandom));
                end while (lane_kind(in_mask[k], in_unassign[k], in_pole[k], in_val[k]) == K_CONF);
            end
        endcase
    endtask

    // Starts at a negedge with lanes set; returns 1ns after the accepting edge.
    task automatic send_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !in_ready; c++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat: in_ready never rose within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        model_beat();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, out_val, conflict, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000", {in_ready, out_valid, out_val, conflict, busy});
        end
        checks++;
        if (out_var !== '0 || out_clause_id !== '0 || conflict_clause_id !== '0) begin
            errors++;
            $display("FAIL reset_values: var %h id %h cid %h want zeros", out_var, out_clause_id, conflict_clause_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready %b busy %b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single_unit();
        logic [VB-1:0] ev;
        @(negedge clk);
        out_ready    = 1'b1;
        in_clause_id = 16'd10;
        set_lane(0, 5'b00011, 5'b00010, 5'b00000, 5'b00000);
        set_lane(1, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
        ev = in_var[0][1];
        send_beat();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_stage: out_valid %b busy %b want 0 1", out_valid, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_var, out_val, out_clause_id} !== {1'b1, ev, 1'b1, 16'd10}) begin
            errors++;
            $display("FAIL single_out: got v%b var %h val %b id %0d want v1 var %h val 1 id 10",
                     out_valid, out_var, out_val, out_clause_id, ev);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_retire: in_ready %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: out_valid %b busy %b want 0 0", out_valid, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_two_units();
        imp_s e;
        @(negedge clk);
        out_ready    = 1'b1;
        in_clause_id = 16'd20;
        unit_lane(0);
        unit_lane(1);
        send_beat();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL two_first_push_ready: in_ready %b want 0", in_ready);
        end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_valid, out_var, out_val, out_clause_id} !== {1'b1, e.v, e.b, CB'(20 + n)}) begin
                errors++;
                $display("FAIL two_out%0d: got v%b var %h val %b id %0d want v1 var %h val %b id %0d",
                         n, out_valid, out_var, out_val, out_clause_id, e.v, e.b, 20 + n);
            end
            if (n == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL two_last_push_ready: in_ready %b want 1", in_ready);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_extra: out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_conflict();
        logic [LITS-1:0] p;
        bit              leaked;
        @(negedge clk);
        out_ready    = 1'b1;
        in_clause_id = 16'h1234;
        unit_lane(0);
        p = LITS'($urandom);
        set_lane(1, 5'b00111, 5'b00000, p, p);
        send_beat();
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_early: conflict %b want 0", conflict);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({conflict, out_valid, in_ready} !== 3'b100 || conflict_clause_id !== exp_conf_id) begin
            errors++;
            $display("FAIL conflict_raise: c%b ov%b ir%b cid %h want c1 ov0 ir0 cid %h",
                     conflict, out_valid, in_ready, conflict_clause_id, exp_conf_id);
        end
        leaked = 0;
        @(negedge clk);
        unit_lane(0);
        unit_lane(1);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) leaked = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL conflict_hold: intake or output while conflicted");
        end
        conflict_clear = 1'b1;
        @(posedge clk);
        #1;
        conflict_clear = 1'b0;
        checks++;
        if ({conflict, in_ready, out_valid, busy} !== 4'b0100 || conflict_clause_id !== 16'h1235) begin
            errors++;
            $display("FAIL conflict_clear: c%b ir%b ov%b busy%b cid %h want 0 1 0 0 cid 1235",
                     conflict, in_ready, out_valid, busy, conflict_clause_id);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        imp_s          e;
        logic [CB-1:0] head_id;
        @(negedge clk);
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_clause_id = CB'($urandom);
            unit_lane(0);
            unit_lane(1);
            send_beat();
        end
        repeat (4) @(posedge clk);
        #1;
        head_id = out_clause_id;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b101 || out_clause_id !== exp_q[0].id) begin
            errors++;
            $display("FAIL bp_stall: ov%b ir%b busy%b head %h want 1 0 1 head %h",
                     out_valid, in_ready, busy, out_clause_id, exp_q[0].id);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_clause_id !== head_id || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable: head %h ir %b want %h 0", out_clause_id, in_ready, head_id);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_var, out_val, out_clause_id} !== {e.v, e.b, e.id}) begin
                    errors++;
                    $display("FAIL bp_order: got var %h val %b id %h want var %h val %b id %h",
                             out_var, out_val, out_clause_id, e.v, e.b, e.id);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: left %0d ov %b busy %b want 0 0 0", exp_q.size(), out_valid, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_corner_classes();
        logic [LITS-1:0] p;
        bit              seen;
        imp_s            e;
        @(negedge clk);
        out_ready    = 1'b1;
        in_clause_id = CB'($urandom);
        set_lane(0, 5'b00000, LITS'($urandom), LITS'($urandom), LITS'($urandom));
        p = LITS'($urandom);
        set_lane(1, 5'b00110, 5'b00110, p, p);
        send_beat();
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || conflict !== 1'b0) seen = 1;
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL corner_empty_open: output or conflict seen, busy %b", busy);
        end
        @(negedge clk);
        in_clause_id = 16'hFFFF;
        sat_lane(0);
        unit_lane(1);
        send_beat();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({out_valid, out_var, out_val, out_clause_id} !== {1'b1, e.v, e.b, 16'h0000}) begin
            errors++;
            $display("FAIL corner_wrap: got v%b var %h val %b id %h want v1 var %h val %b id 0000",
                     out_valid, out_var, out_val, out_clause_id, e.v, e.b);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic test_random();
        bit   drv_done;
        bit   hold;
        imp_s prev;
        imp_s e;
        drv_done = 0;
        hold     = 0;
        prev     = '{default: '0};
        fork
            begin
                for (int b = 0; b < 150; b++) begin
                    @(negedge clk);
                    in_clause_id = CB'($urandom);
                    for (int k = 0; k < LANES; k++) rand_lane(k);
                    in_valid = 1'b1;
                    for (int c = 0; c < 200 && !in_ready; c++) @(negedge clk);
                    if (!in_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_intake: in_ready stuck low");
                        break;
                    end
                    model_beat();
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    if ($urandom_range(0, 2) == 0) @(negedge clk);
                end
                drv_done = 1;
            end
            begin
                for (int c = 0; c < 20000; c++) begin
                    @(negedge clk);
                    if (hold) begin
                        checks++;
                        if ({out_valid, out_var, out_val, out_clause_id} !== {1'b1, prev.v, prev.b, prev.id}) begin
                            errors++;
                            $display("FAIL rand_stable: head changed while stalled, id %h want %h",
                                     out_clause_id, prev.id);
                        end
                    end
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra: unexpected output id %h", out_clause_id);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_var, out_val, out_clause_id} !== {e.v, e.b, e.id}) begin
                                errors++;
                                $display("FAIL rand_out: got var %h val %b id %h want var %h val %b id %h",
                                         out_var, out_val, out_clause_id, e.v, e.b, e.id);
                            end
                        end
                    end
                    hold    = out_valid && !out_ready;
                    prev.v  = out_var;
                    prev.b  = out_val;
                    prev.id = out_clause_id;
                    if (drv_done && exp_q.size() == 0 && !busy) break;
                end
            end
        join
        checks++;
        if (exp_q.size() != 0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL rand_leftover: %0d implications missing, conflict %b", exp_q.size(), conflict);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clk);
        out_ready    = 1'b0;
        in_clause_id = CB'($urandom);
        unit_lane(0);
        unit_lane(1);
        send_beat();
        @(negedge clk);
        in_clause_id = CB'($urandom);
        unit_lane(0);
        sat_lane(1);
        send_beat();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy} !== 2'b11 || out_clause_id !== exp_q[0].id) begin
            errors++;
            $display("FAIL mid_fill: ov%b busy%b head %h want 1 1 %h", out_valid, busy, out_clause_id, exp_q[0].id);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_val, conflict, busy} !== 5'b10000 ||
            out_var !== '0 || out_clause_id !== '0 || conflict_clause_id !== '0) begin
            errors++;
            $display("FAIL mid_reset: ir%b ov%b val%b c%b busy%b var %h id %h cid %h want 1 0 0 0 0 zeros",
                     in_ready, out_valid, out_val, conflict, busy, out_var, out_clause_id, conflict_clause_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: busy %b ov %b want 0 0", busy, out_valid);
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        conflict_clear = 1'b0;
        in_clause_id   = '0;
        in_unassign    = '0;
        in_mask        = '0;
        in_pole        = '0;
        in_val         = '0;
        in_var         = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_unit();
        test_two_units();
        test_conflict();
        test_backpressure();
        test_corner_classes();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clause_eval_pipe.md
# clause_eval_pipe

Pipelined, multi-lane clause evaluator for the BCP datapath, parametrised in literals per clause and in clauses per beat. Each accepted beat is classified per lane as empty, satisfied, unit, conflict or open. Unit implications are serialised into a small output FIFO. Any conflict raises a sticky flag and halts intake until the controller clears it. It sits between the clause fetch stage and the implication/trail logic.

## Interface
- `LITS`, 5, literals per clause (≥2)
- `LANES`, 2, clauses evaluated per beat (≥1)
- `VAR_BITS`, `` `MAX_VARS_BITS ``, variable index width
- `CID_BITS`, 16, clause-ID width
- `DEPTH`, 4, implication FIFO entries (power of 2, ≥2)

Ports:
- `clk` in 1: the only clock
- `rst_n` in 1: reset, asynchronous and active-low
- `in_valid` in 1 / `in_ready` out 1: beat handshake; a beat transfers when both are high at a rising edge
- `in_clause_id` in CID_BITS: ID of lane 0; lane k has ID `in_clause_id + k` (mod 2^CID_BITS)
- `in_unassign`, `in_mask`, `in_pole`, `in_val` in [LANES][LITS]: per-literal bits
- `in_var` in [LANES][LITS][VAR_BITS]: variable index per literal
- `out_valid` out 1 / `out_ready` in 1: implication handshake
- `out_var` out VAR_BITS, `out_val` out 1, `out_clause_id` out CID_BITS: head implication
- `conflict` out 1: sticky conflict flag
- `conflict_clause_id` out CID_BITS: ID of the lowest conflicting lane
- `conflict_clear` in 1: clears `conflict` and flushes the FIFO
- `busy` out 1: high when the stage holds a beat or the FIFO is not empty

## Operation
Per-literal terms (lane k, literal i):
- active = `mask`
- true = active & ~unassign & (val ^ pole)
- free = active & unassign

Lane classification, in priority order:
- EMPTY if no literal is active
- SAT if any literal is true
- UNIT if exactly one literal is free
- CONFLICT if no literal is free
- otherwise OPEN

A UNIT lane implies `var` = `in_var[k][i]` of the free literal, `val` = ~`pole[k][i]`, clause ID = lane ID.

Stage register:
- Holds one accepted beat and a `pending` mask of its UNIT lanes.
- Classification is combinational from the stage contents.

Each cycle while the stage is valid:
- **Conflict path.** If any lane is CONFLICT: set `conflict`, latch `conflict_clause_id` from the lowest such lane, discard the beat, and push nothing from it.
- **Push path.** Otherwise, if `pending`≠0 and the FIFO is not full: push the lowest pending lane's implication and clear its bit.
- **Retire.** The beat retires when there is no conflict and either `pending`==0 or the last pending bit is pushed this cycle.

Intake:
- `in_ready` = ~`conflict` & (~stage_valid | retire). This allows back-to-back beats with no bubble.

FIFO:
- Push only when not full; there is no full pass-through.
- A pop occurs on `out_valid` & `out_ready`.
- A simultaneous push and pop leaves the count unchanged.
- Pointers wrap mod DEPTH; the count is log2(DEPTH)+1 bits wide.

`conflict_clear`:
- Honoured only while `conflict`=1.
- Next cycle: `conflict`=0, FIFO empty, `conflict_clause_id` keeps its value.
- Ignored while `conflict`=0.

Arithmetic:
- Lane ID addition wraps silently.
- UNIT detection uses an exact one-hot test on the free vector, not a priority encode.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_var`/`out_val`/`out_clause_id`=0, `conflict`=0, `conflict_clause_id`=0, `busy`=0. The stage and FIFO are empty.
- **Latency:** a beat accepted at edge T is in the stage during cycle T+1. Its first implication is pushed at edge T+2 and appears on `out_*` in cycle T+2. `conflict` rises at edge T+2.
- **Drain rate:** one implication per cycle. A beat with u unit lanes occupies the stage for max(1,u) cycles when the FIFO never fills.
- **Flow control:** `out_*` is stable while `out_valid`=1 and `out_ready`=0. `in_*` is sampled only on transfer.
- **Reset mid-operation:** all state clears immediately and asynchronously; in-flight implications are lost.

## Structure
- Package `clause_pkg` holds:
  - `lane_class_e` {CL_EMPTY, CL_SAT, CL_UNIT, CL_CONFLICT, CL_OPEN}
  - `implication_t` {var, val, clause_id}
  - default LITS/LANES constants
- Sub-module `clause_classifier`: combinational, one per lane. Outputs class, implied var and val.
- Stage control, serialiser and FIFO live in the top module.

## Test plan
- **Single unit:** LANES=2, id=10. Lane 0 is mask=00011, unassign=00010, val=0, pole=00000; lane 1 is SAT. Expect one output (var=in_var[0][1], val=1, id=10) in cycle T+2, then the stage retires.
- **Two units, one beat:** both lanes UNIT, id=20. Expect outputs id 20 then id 21 on consecutive cycles. `in_ready` stays low during the first push and is high during the last push.
- **Conflict:** lane 1 has mask=00111, all assigned false; lane 0 is UNIT. Expect `conflict`=1 and `conflict_clause_id`=id+1 at T+2, no lane 0 implication, and `in_ready`=0. After `conflict_clear`, expect `in_ready`=1 and `out_valid`=0.
- **Backpressure:** `out_ready`=0 and 6 unit lanes are fed with DEPTH=4. Expect the FIFO to hold 4, `in_ready`=0 and the stage stalled. Releasing `out_ready` delivers all 6 in order with none lost or duplicated.
- **Corner classes:** mask=00000 gives EMPTY with no output. Two free literals give OPEN with no output. Clause ID 0xFFFF on lane 1 gives 0x0000 on the lane 1 output.
- **Reset mid-drain:** assert `rst_n`=0 while the FIFO holds 3 entries. Expect all outputs at reset values immediately and `busy`=0 after release.
